roll_sequencer: RTL
===================

Name: roll_sequencer

Overview:
- Control sequencer for the 4-bit dice/random-display datapath.
- Turns user key pulses (start, stop, recall) into control for an external 16-bit LFSR: a seed-load strobe, a run enable, and a decelerating schedule of display-update steps.
- Commits each final result into a 4-entry history and lets the user browse that history while idle.
- Sits between the key debouncers/pulse generators and the LFSR plus 7-segment output.

Parameters:
- BASE_LOG2, 9: log2 of the step interval in stage 0; stage k steps every 2^(BASE_LOG2+k) cycles.
- STAGE_LOG2, 13: log2 of cycles per stage; 4 stages; run length is 2^(STAGE_LOG2+2). Legal only when BASE_LOG2+3 <= STAGE_LOG2.
- HIST_DEPTH, 4: history entries; fixed at 4 (2-bit index).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse
- i_stop  in  1  one-cycle pause/stop pulse
- i_recall  in  1  one-cycle pulse; browse history
- i_rand  in  4  LFSR low nibble, valid every cycle
- o_seed_load  out  1  one-cycle strobe: LFSR loads state XOR free-running seed
- o_lfsr_en  out  1  LFSR advances one step per cycle while high
- o_step  out  1  one-cycle pulse: o_value just updated from i_rand
- o_value  out  4  value to display
- o_busy  out  1  high in RUN and COMMIT
- o_recall_valid  out  1  o_value is showing a history entry
- o_recall_idx  out  2  0 = newest entry

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low. All outputs and registers are 0 in reset; state is IDLE; history count is 0.
- All outputs are registered. Inputs are sampled on the rising edge.
- States: IDLE, RUN, COMMIT.
- IDLE -> RUN when i_start=1 at edge t.
  - At t+1: o_seed_load=1 for exactly one cycle, o_lfsr_en=1, run counter cnt=0, o_recall_valid=0.
- RUN:
  - cnt has width STAGE_LOG2+2 and increments every cycle.
  - Stage s = cnt[top 2 bits].
  - Step condition: the low BASE_LOG2+s bits of cnt are all ones.
  - On a step, o_value <= i_rand and o_step=1 on the next cycle.
  - With defaults, stages produce 16, 8, 4 and 2 steps: 30 total.
- RUN -> COMMIT on cnt = all-ones (natural end) or i_stop=1.
  - Natural end: a step also fires at the final count, so the final value is that i_rand.
  - i_stop: the final value is i_rand if the step condition holds in that same cycle, otherwise the current o_value.
  - o_lfsr_en drops in the COMMIT cycle.
- COMMIT (1 cycle):
  - Push the final value into history: shift entries, newest at index 0, oldest dropped when full.
  - Count saturates at 4.
  - Go to IDLE; o_busy falls one cycle later.
- IDLE recall:
  - If count=0, i_recall is ignored.
  - If o_recall_valid=0, the first i_recall sets idx=0 and o_recall_valid=1.
  - Each further i_recall does idx = (idx+1) mod count.
  - o_value = history[idx], updated the cycle after the pulse.
- Ignored inputs:
  - i_start in RUN or COMMIT.
  - i_stop in IDLE or COMMIT.
  - i_recall outside IDLE.
- Simultaneous events:
  - i_start and i_recall in the same cycle: start wins, recall is dropped.
  - i_start and i_stop in IDLE: start wins.
- Reset mid-RUN: immediate abort, no history push, all outputs 0.

Test Plan:
- Reset, then i_start at t -> o_seed_load=1 only at t+1; o_busy=1; first o_step at cnt=511 (t+513 with defaults).
- Full run, i_rand held at 4'h7 -> exactly 30 o_step pulses; o_busy low 32769 cycles after RUN entry; history[0]=7; count=1.
- Stop mid-stage: i_stop at cnt=1000, i_rand=4'hA, last step showed 4'h3 -> committed value 4'h3. Repeat with i_stop at cnt=1023 (step cycle) -> commits 4'hA.
- Five runs committing 1,2,3,4,5, then 5 i_recall pulses -> o_value sequence 5,4,3,2,5; o_recall_idx 0,1,2,3,0; oldest value 1 never appears.
- i_recall with empty history -> o_recall_valid stays 0. i_recall and i_start in the same cycle -> RUN entered, o_recall_valid=0.
- i_rst_n low at cnt=20000 -> outputs 0 asynchronously; after release the history count is 0 and a new i_start behaves as in the first scenario.

Source files
------------

// File: rtl/roll_sequencer.sv
// roll_sequencer: control sequencer for the dice/random-display datapath.
// Converts start/stop/recall key pulses into LFSR control (seed strobe,
// run enable), a decelerating schedule of display steps, and a 4-entry
// history of committed results that can be browsed while idle.
// Legal parameter range: BASE_LOG2 + 3 <= STAGE_LOG2.
module roll_sequencer #(
    parameter int BASE_LOG2  = 9,
    parameter int STAGE_LOG2 = 13,
    parameter int HIST_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_recall,
    input  logic [3:0] i_rand,
    output logic       o_seed_load,
    output logic       o_lfsr_en,
    output logic       o_step,
    output logic [3:0] o_value,
    output logic       o_busy,
    output logic       o_recall_valid,
    output logic [1:0] o_recall_idx
);

    // Run counter spans four stages of 2^STAGE_LOG2 cycles each.
    localparam int CW = STAGE_LOG2 + 2;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [3:0]      r_value;
    logic [3:0]      w_value_next;
    logic            r_step;
    logic            w_step_next;
    logic            r_seed_load;
    logic            w_seed_load_next;
    logic            r_lfsr_en;
    logic            w_lfsr_en_next;
    logic            r_busy;
    logic            w_busy_next;
    logic            r_recall_valid;
    logic            w_recall_valid_next;
    logic [1:0]      r_recall_idx;
    logic [1:0]      w_recall_idx_next;

    // History: entry 0 is the newest committed value.
    logic [3:0]      r_hist [HIST_DEPTH];
    logic [2:0]      r_hist_cnt;
    logic            w_hist_push;

    logic [CW-1:0]   w_step_mask;
    logic            w_step_hit;
    logic            w_cnt_last;
    logic [2:0]      w_idx_inc;
    logic [1:0]      w_idx_wrap;

    // Step mask widens by one bit per stage, halving the step rate each stage.
    always_comb begin
        w_step_mask = (ONE << BASE_LOG2) - ONE;
        case (r_cnt[CW-1 -: 2])
            2'd0:    w_step_mask = (ONE << BASE_LOG2) - ONE;
            2'd1:    w_step_mask = (ONE << (BASE_LOG2 + 1)) - ONE;
            2'd2:    w_step_mask = (ONE << (BASE_LOG2 + 2)) - ONE;
            default: w_step_mask = (ONE << (BASE_LOG2 + 3)) - ONE;
        endcase
    end

    assign w_step_hit = ((r_cnt & w_step_mask) == w_step_mask);
    assign w_cnt_last = &r_cnt;

    // Next browse index wraps modulo the number of valid history entries.
    assign w_idx_inc  = {1'b0, r_recall_idx} + 3'd1;
    assign w_idx_wrap = (w_idx_inc >= r_hist_cnt) ? 2'd0 : w_idx_inc[1:0];

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_value_next        = r_value;
        w_step_next         = 1'b0;
        w_seed_load_next    = 1'b0;
        w_lfsr_en_next      = 1'b0;
        w_recall_valid_next = r_recall_valid;
        w_recall_idx_next   = r_recall_idx;
        w_hist_push         = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    // Start beats a simultaneous recall or stop.
                    w_state_next        = S_RUN;
                    w_cnt_next          = '0;
                    w_seed_load_next    = 1'b1;
                    w_lfsr_en_next      = 1'b1;
                    w_recall_valid_next = 1'b0;
                    w_recall_idx_next   = 2'd0;
                end else if (i_recall && (r_hist_cnt != 3'd0)) begin
                    w_recall_valid_next = 1'b1;
                    if (!r_recall_valid) begin
                        w_recall_idx_next = 2'd0;
                        w_value_next      = r_hist[0];
                    end else begin
                        w_recall_idx_next = w_idx_wrap;
                        w_value_next      = r_hist[w_idx_wrap];
                    end
                end
            end
            S_RUN: begin
                w_cnt_next     = r_cnt + ONE;
                w_lfsr_en_next = 1'b1;
                if (w_step_hit) begin
                    w_value_next = i_rand;
                    w_step_next  = 1'b1;
                end
                if (w_cnt_last || i_stop) begin
                    // o_value now carries the final result for the commit.
                    w_state_next   = S_COMMIT;
                    w_lfsr_en_next = 1'b0;
                end
            end
            S_COMMIT: begin
                w_hist_push  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_busy_next = (w_state_next != S_IDLE);
    end

    // Registered outputs and run counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt          <= '0;
            r_value        <= '0;
            r_step         <= 1'b0;
            r_seed_load    <= 1'b0;
            r_lfsr_en      <= 1'b0;
            r_busy         <= 1'b0;
            r_recall_valid <= 1'b0;
            r_recall_idx   <= 2'd0;
        end else begin
            r_cnt          <= w_cnt_next;
            r_value        <= w_value_next;
            r_step         <= w_step_next;
            r_seed_load    <= w_seed_load_next;
            r_lfsr_en      <= w_lfsr_en_next;
            r_busy         <= w_busy_next;
            r_recall_valid <= w_recall_valid_next;
            r_recall_idx   <= w_recall_idx_next;
        end
    end

    // History shift register: newest enters at 0, oldest falls off the end.
    genvar gi;
    generate
        for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                // Head entry takes the committed value.
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_hist[gi] <= 4'd0;
                    end else if (w_hist_push) begin
                        r_hist[gi] <= r_value;
                    end
                end
            end else begin : g_tail
                // Older entries move down one slot on each commit.
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_hist[gi] <= 4'd0;
                    end else if (w_hist_push) begin
                        r_hist[gi] <= r_hist[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Number of valid history entries, saturating at the history depth.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist_cnt <= 3'd0;
        end else if (w_hist_push && (r_hist_cnt != 3'(HIST_DEPTH))) begin
            r_hist_cnt <= r_hist_cnt + 3'd1;
        end
    end

    assign o_seed_load    = r_seed_load;
    assign o_lfsr_en      = r_lfsr_en;
    assign o_step         = r_step;
    assign o_value        = r_value;
    assign o_busy         = r_busy;
    assign o_recall_valid = r_recall_valid;
    assign o_recall_idx   = r_recall_idx;

endmodule
